eth_rx_frame_filter: RTL

Store-and-forward receive filter between the 10G MAC receive AXI-Stream (no back-pressure) and the `eth_encap` data FIFO in the `clk156` domain. Each frame is buffered whole. The frame is committed to the output only if it ends with `tuser=0`, meets the minimum length, and fit in the buffer; otherwise it is rolled back and never reaches the output. Downstream therefore sees only complete, good frames, and can stop re-checking `tuser`.

---
 rtl/eth_pkg.sv | 27 ++
 rtl/eth_sdp_ram.sv | 28 ++
 rtl/eth_rx_frame_filter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet beat definitions: widths, the buffered beat layout and the
// receive-filter write-FSM states.
package eth_pkg;

  localparam int ETH_DATA_W = 64;
  localparam int ETH_KEEP_W = 8;

  typedef struct packed {
    logic [ETH_DATA_W-1:0] data;
    logic [ETH_KEEP_W-1:0] keep;
    logic                  last;
  } eth_beat_t;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_FRAME = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_e;

  function automatic logic [3:0] keep_bytes(input logic [ETH_KEEP_W-1:0] keep);
    keep_bytes = '0;
    for (int i = 0; i < ETH_KEEP_W; i++) begin
      keep_bytes = keep_bytes + {3'd0, keep[i]};
    end
  endfunction

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-gated read (read data holds while re_i is low).
module eth_sdp_ram #(
  parameter int WIDTH  = 73,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array and its read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_rx_frame_filter.sv
// Store-and-forward MAC receive filter: only whole, good, long-enough frames
// that fit the buffer reach the output. Define ETH_RX_FILTER_STATS_EN for counters.
module eth_rx_frame_filter
  import eth_pkg::*;
#(
  parameter int DEPTH     = 512,
  parameter int MIN_BYTES = 60
) (
  input  logic                  clk156,
  input  logic                  eth_rst_n,
  input  logic                  s_axis_rx_tvalid,
  input  logic [ETH_DATA_W-1:0] s_axis_rx_tdata,
  input  logic [ETH_KEEP_W-1:0] s_axis_rx_tkeep,
  input  logic                  s_axis_rx_tlast,
  input  logic                  s_axis_rx_tuser,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [ETH_DATA_W-1:0] m_axis_tdata,
  output logic [ETH_KEEP_W-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
`ifdef ETH_RX_FILTER_STATS_EN
  ,
  output logic [31:0]           stat_good_frames,
  output logic [31:0]           stat_drop_frames
`endif
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};
  localparam logic [15:0] MIN_LEN  = 16'(MIN_BYTES);

  wr_state_e   state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] commit_ptr_q, commit_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [16:0] byte_sum;
  logic [15:0] frame_bytes;
  logic        full, wr_en, do_commit, do_drop;
  eth_beat_t   wr_beat;

  eth_beat_t   ram_rdata, skid_q, head;
  logic        ram_vld_q, ram_vld_d, skid_vld_q, skid_vld_d;
  logic        rd_en, pop, skid_load;

  // Full is judged on the registered rd_ptr, so it can lag a read by one cycle.
  assign full        = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
  assign byte_sum    = {1'b0, (state_q == WR_FRAME) ? byte_cnt_q : 16'd0}
                     + {13'd0, keep_bytes(s_axis_rx_tkeep)};
  assign frame_bytes = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
  assign wr_beat     = {s_axis_rx_tdata, s_axis_rx_tkeep, s_axis_rx_tlast};

  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    wr_en      = 1'b0;
    do_commit  = 1'b0;
    do_drop    = 1'b0;
    if (s_axis_rx_tvalid) begin
      case (state_q)
        WR_IDLE, WR_FRAME: begin
          if (full) begin
            state_d = s_axis_rx_tlast ? WR_IDLE : WR_DROP;
            do_drop = s_axis_rx_tlast;
          end else begin
            wr_en      = 1'b1;
            byte_cnt_d = frame_bytes;
            if (s_axis_rx_tlast) begin
              state_d   = WR_IDLE;
              do_commit = !s_axis_rx_tuser && (frame_bytes >= MIN_LEN);
              do_drop   = !do_commit;
            end else begin
              state_d = WR_FRAME;
            end
          end
        end
        WR_DROP: begin
          if (s_axis_rx_tlast) begin
            state_d = WR_IDLE;
            do_drop = 1'b1;
          end
        end
        default: state_d = WR_IDLE;
      endcase
    end
  end

  assign wr_ptr_d     = do_drop ? commit_ptr_q : (wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q);
  assign commit_ptr_d = do_commit ? wr_ptr_q + 1'b1 : commit_ptr_q;

  // Read pipeline: the RAM read register is the head; the skid register catches
  // it when a new read lands while the head is stalled.
  assign rd_en     = (rd_ptr_q != commit_ptr_q) && !skid_vld_q;
  assign rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, rd_en};
  assign head      = skid_vld_q ? skid_q : ram_rdata;
  assign pop       = m_axis_tvalid && m_axis_tready;
  assign skid_load = rd_en && ram_vld_q && !pop;

  always_comb begin
    ram_vld_d  = ram_vld_q && !pop;
    skid_vld_d = 1'b0;
    if (skid_vld_q) begin
      ram_vld_d  = ram_vld_q;
      skid_vld_d = !pop;
    end else if (rd_en) begin
      ram_vld_d  = 1'b1;
      skid_vld_d = skid_load;
    end
  end

  eth_sdp_ram #(
    .WIDTH  ($bits(eth_beat_t)),
    .DEPTH  (DEPTH),
    .ADDR_W (AW)
  ) u_ram (
    .clk     (clk156),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_beat),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      state_q      <= WR_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      byte_cnt_q   <= '0;
      ram_vld_q    <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      ram_vld_q    <= ram_vld_d;
      skid_vld_q   <= skid_vld_d;
      if (skid_load) skid_q <= ram_rdata;
    end
  end

  assign m_axis_tvalid = ram_vld_q || skid_vld_q;
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast} = m_axis_tvalid ? head : '0;
  assign m_axis_tuser  = 1'b0;

`ifdef ETH_RX_FILTER_STATS_EN
  logic [31:0] stat_good_q, stat_drop_q;

  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      stat_good_q <= '0;
      stat_drop_q <= '0;
    end else begin
      if (do_commit) stat_good_q <= stat_good_q + 32'd1;
      if (do_drop)   stat_drop_q <= stat_drop_q + 32'd1;
    end
  end

  assign stat_good_frames = stat_good_q;
  assign stat_drop_frames = stat_drop_q;
`endif

endmodule
